// File: rtl/alu_pkg.sv
// Shared ALU definitions: default widths, opcode encodings and a sizing helper
// used by the operand-sharing arbiter and its round-robin picker.
package alu_pkg;

   localparam int ALU_DATA_WIDTH    = 32;
   localparam int ALU_OPCODE_LENGTH = 4;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0011;
   localparam logic [3:0] ALU_SLL = 4'b0100;
   localparam logic [3:0] ALU_SRL = 4'b0101;
   localparam logic [3:0] ALU_SRA = 4'b0111;
   localparam logic [3:0] ALU_EQ  = 4'b1000;
   localparam logic [3:0] ALU_NE  = 4'b1001;
   localparam logic [3:0] ALU_LT  = 4'b1011;
   localparam logic [3:0] ALU_XOR = 4'b1101;
   localparam logic [3:0] ALU_GE  = 4'b1111;

   // Index width for n requesters, never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible index at or after ptr,
// found by rotating a doubled request vector and priority-encoding it.
module rr_pick
   import alu_pkg::*;
#(
   parameter  int NUM_REQ = 2,
   localparam int IDX_W   = idx_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] elig,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   idx,
   output logic               any
);

   localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W+1)'(NUM_REQ);

   logic [NUM_REQ-1:0] rot;
   logic [IDX_W-1:0]   off;
   logic [IDX_W:0]     sum;
   logic               found;

   // rot[k] is requester (ptr + k) mod NUM_REQ.
   always_comb begin
      rot   = NUM_REQ'({elig, elig} >> ptr);
      any   = |rot;
      off   = '0;
      found = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (rot[k] && !found) begin
            found = 1'b1;
            off   = IDX_W'(k);
         end
      end
   end

   always_comb begin
      sum = {1'b0, ptr} + {1'b0, off};
      if (sum >= NUM_REQ_W) begin
         sum = sum - NUM_REQ_W;
      end
      idx = any ? sum[IDX_W-1:0] : '0;
      gnt = '0;
      if (any) begin
         gnt[idx] = 1'b1;
      end
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU among NUM_REQ valid/ready requesters, granting
// round-robin and registering each result in a per-requester response slot.
module alu_share_arbiter
   import alu_pkg::*;
#(
   parameter  int DATA_WIDTH    = ALU_DATA_WIDTH,
   parameter  int OPCODE_LENGTH = ALU_OPCODE_LENGTH,
   parameter  int NUM_REQ       = 2,
   localparam int IDX_W         = idx_width(NUM_REQ)
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             flush,
   input  logic [NUM_REQ-1:0]               req_valid,
   output logic [NUM_REQ-1:0]               req_ready,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_srca,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_srcb,
   input  logic [NUM_REQ*OPCODE_LENGTH-1:0] req_op,
   output logic [NUM_REQ-1:0]               rsp_valid,
   input  logic [NUM_REQ-1:0]               rsp_ready,
   output logic [NUM_REQ*DATA_WIDTH-1:0]    rsp_data,
   output logic [DATA_WIDTH-1:0]            alu_srca,
   output logic [DATA_WIDTH-1:0]            alu_srcb,
   output logic [OPCODE_LENGTH-1:0]         alu_op,
   input  logic [DATA_WIDTH-1:0]            alu_result,
   output logic [IDX_W-1:0]                 grant_idx
);

   // Handshake: a request transfers when req_valid[i] && req_ready[i];
   // a result transfers when rsp_valid[i] && rsp_ready[i]. req_ready depends
   // combinationally on req_valid/rsp_ready, so req_valid must not depend on req_ready.

   logic [NUM_REQ-1:0]            rsp_valid_q, rsp_valid_d;
   logic [NUM_REQ*DATA_WIDTH-1:0] rsp_data_q,  rsp_data_d;
   logic [IDX_W-1:0]              rr_ptr_q,    rr_ptr_d;

   logic [NUM_REQ-1:0] elig;
   logic [NUM_REQ-1:0] gnt;
   logic [IDX_W-1:0]   gnt_idx;
   logic               gnt_any;

   // A full slot that is not draining is skipped so other requesters keep flowing.
   always_comb begin
      elig = req_valid & (~rsp_valid_q | rsp_ready);
      if (flush || !rst_n) begin
         elig = '0;
      end
   end

   rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_pick (
      .elig (elig),
      .ptr  (rr_ptr_q),
      .gnt  (gnt),
      .idx  (gnt_idx),
      .any  (gnt_any)
   );

   assign req_ready = gnt;
   assign grant_idx = gnt_idx;

   always_comb begin
      alu_srca = '0;
      alu_srcb = '0;
      alu_op   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            alu_srca = req_srca[i*DATA_WIDTH +: DATA_WIDTH];
            alu_srcb = req_srcb[i*DATA_WIDTH +: DATA_WIDTH];
            alu_op   = req_op[i*OPCODE_LENGTH +: OPCODE_LENGTH];
         end
      end
   end

   // A grant to a draining slot refills it in the same edge, so no bubble.
   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (flush) begin
            rsp_valid_d[i] = 1'b0;
         end else if (gnt[i]) begin
            rsp_valid_d[i]                         = 1'b1;
            rsp_data_d[i*DATA_WIDTH +: DATA_WIDTH] = alu_result;
         end else if (rsp_valid_q[i] && rsp_ready[i]) begin
            rsp_valid_d[i] = 1'b0;
         end
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (flush) begin
         rr_ptr_d = '0;
      end else if (gnt_any) begin
         rr_ptr_d = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
         rr_ptr_q    <= '0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed vectors, corner-case sequences and a
// randomized run against a slot/pointer reference model.
module tb_alu_share_arbiter;
   import alu_pkg::*;

   localparam int NR = 2;
   localparam int DW = 32;
   localparam int OW = 4;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               flush = 1'b0;
   logic [NR-1:0]      req_valid = '0;
   logic [NR-1:0]      req_ready;
   logic [NR*DW-1:0]   req_srca = '0;
   logic [NR*DW-1:0]   req_srcb = '0;
   logic [NR*OW-1:0]   req_op = '0;
   logic [NR-1:0]      rsp_valid;
   logic [NR-1:0]      rsp_ready = '0;
   logic [NR*DW-1:0]   rsp_data;
   logic [DW-1:0]      alu_srca, alu_srcb, alu_result;
   logic [OW-1:0]      alu_op;
   logic [0:0]         grant_idx;

   int n_total = 0;
   int n_pass  = 0;

   logic [DW-1:0] exp_q[$];
   int            exp_idx_q[$];

   logic [3:0]  f_op [NR];
   logic [31:0] f_a  [NR];
   logic [31:0] f_b  [NR];

   logic        m_valid [NR];
   logic [31:0] m_data  [NR];
   int          m_ptr;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
   } vec_t;
   vec_t vecs[12];

   localparam logic [3:0] OPS [12] = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLL, ALU_SRL,
                                        ALU_SRA, ALU_EQ, ALU_NE, ALU_LT, ALU_XOR, ALU_GE};

   alu_share_arbiter #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OW), .NUM_REQ(NR)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_srca(req_srca), .req_srcb(req_srcb), .req_op(req_op),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_op(alu_op),
      .alu_result(alu_result), .grant_idx(grant_idx)
   );

   // clock / reset
   always #5 clk = ~clk;

   function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         ALU_AND: return a & b;
         ALU_OR:  return a | b;
         ALU_ADD: return a + b;
         ALU_SUB: return a - b;
         ALU_SLL: return a << b[4:0];
         ALU_SRL: return a >> b[4:0];
         ALU_SRA: return $unsigned($signed(a) >>> b[4:0]);
         ALU_EQ:  return {31'b0, a == b};
         ALU_NE:  return {31'b0, a != b};
         ALU_LT:  return {31'b0, $signed(a) < $signed(b)};
         ALU_XOR: return a ^ b;
         ALU_GE:  return {31'b0, $signed(a) >= $signed(b)};
         default: return 32'h0;
      endcase
   endfunction

   assign alu_result = alu_f(alu_op, alu_srca, alu_srcb);

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // driver tasks
   task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      f_op[i] = op;
      f_a[i]  = a;
      f_b[i]  = b;
      req_op[i*OW +: OW]   = op;
      req_srca[i*DW +: DW] = a;
      req_srcb[i*DW +: DW] = b;
   endtask

   task automatic drive(input logic [NR-1:0] vld, input logic [NR-1:0] rdy, input logic fl);
      @(negedge clk);
      req_valid = vld;
      rsp_ready = rdy;
      flush     = fl;
      #1;
   endtask

   task automatic edge_wait();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] slot(input int i);
      logic [NR*DW-1:0] d;
      d = rsp_data;
      return d[i*DW +: DW];
   endfunction

   task automatic random_cycle();
      logic [NR-1:0] rv, rr, exp_gnt;
      logic          fl;
      int            g;
      logic [31:0]   res;
      @(negedge clk);
      fl = ($urandom_range(0, 31) == 0);
      rv = NR'($urandom_range(0, 3));
      rr = NR'($urandom_range(0, 3));
      for (int i = 0; i < NR; i++)
         set_req(i, OPS[$urandom_range(0, 11)], $urandom, $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 40)) : $urandom);
      req_valid = rv;
      rsp_ready = rr;
      flush     = fl;
      #1;
      g = -1;
      for (int k = 0; k < NR; k++) begin
         int j;
         j = (m_ptr + k) % NR;
         if (g < 0 && !fl && rv[j] && (!m_valid[j] || rr[j])) g = j;
      end
      exp_gnt = '0;
      if (g >= 0) exp_gnt[g] = 1'b1;
      check("rnd_req_ready", 64'(req_ready), 64'(exp_gnt));
      check("rnd_grant_idx", 64'(grant_idx), (g >= 0) ? 64'(g) : 64'd0);
      check("rnd_alu_op",   64'(alu_op),   (g >= 0) ? 64'(f_op[g]) : 64'd0);
      check("rnd_alu_srca", 64'(alu_srca), (g >= 0) ? 64'(f_a[g]) : 64'd0);
      check("rnd_alu_srcb", 64'(alu_srcb), (g >= 0) ? 64'(f_b[g]) : 64'd0);
      res = (g >= 0) ? alu_f(f_op[g], f_a[g], f_b[g]) : 32'h0;
      if (g >= 0) begin
         exp_q.push_back(res);
         exp_idx_q.push_back(g);
      end
      for (int i = 0; i < NR; i++) begin
         if (fl) m_valid[i] = 1'b0;
         else if (i == g) begin m_valid[i] = 1'b1; m_data[i] = res; end
         else if (m_valid[i] && rr[i]) m_valid[i] = 1'b0;
      end
      if (fl) m_ptr = 0;
      else if (g >= 0) m_ptr = (g + 1) % NR;
      edge_wait();
      // scoreboard: the result accepted at the last edge
      if (exp_q.size() > 0) begin
         int          ei;
         logic [31:0] ed;
         ed = exp_q.pop_front();
         ei = exp_idx_q.pop_front();
         check("rnd_captured_result", 64'(slot(ei)), 64'(ed));
      end
      for (int i = 0; i < NR; i++) begin
         check("rnd_rsp_valid", 64'(rsp_valid[i]), 64'(m_valid[i]));
         if (m_valid[i]) check("rnd_rsp_data", 64'(slot(i)), 64'(m_data[i]));
      end
   endtask

   initial begin
      vecs[0]  = '{ALU_ADD, 32'd5,         32'd7,        32'd12};
      vecs[1]  = '{ALU_SUB, 32'd10,        32'd3,        32'd7};
      vecs[2]  = '{ALU_AND, 32'h0000F0F0,  32'h0000FF00, 32'h0000F000};
      vecs[3]  = '{ALU_OR,  32'h0000F0F0,  32'h0000FF00, 32'h0000FFF0};
      vecs[4]  = '{ALU_XOR, 32'h000000F0,  32'h0000000F, 32'h000000FF};
      vecs[5]  = '{ALU_SLL, 32'd1,         32'd4,        32'd16};
      vecs[6]  = '{ALU_SRL, 32'h80000000,  32'd31,       32'd1};
      vecs[7]  = '{ALU_SRA, 32'h80000000,  32'd4,        32'hF8000000};
      vecs[8]  = '{ALU_EQ,  32'd5,         32'd5,        32'd1};
      vecs[9]  = '{ALU_NE,  32'd5,         32'd5,        32'd0};
      vecs[10] = '{ALU_LT,  32'hFFFFFFFF,  32'd1,        32'd1};
      vecs[11] = '{ALU_GE,  32'hFFFFFFFF,  32'd1,        32'd0};

      for (int i = 0; i < NR; i++) set_req(i, ALU_AND, 32'h0, 32'h0);

      // reset held with both requesting
      rst_n = 1'b0;
      drive(2'b11, 2'b00, 1'b0);
      check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      check("reset_rsp_data",  64'(rsp_data),  64'd0);
      check("reset_req_ready", 64'(req_ready), 64'd0);
      check("reset_alu_op",    64'(alu_op),    64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("first_grant_req0", 64'(req_ready), 64'b01);
      drive(2'b00, 2'b11, 1'b0);
      edge_wait();

      // single requester ADD 5+7
      drive(2'b00, 2'b11, 1'b1);
      set_req(0, ALU_ADD, 32'd5, 32'd7);
      drive(2'b01, 2'b00, 1'b0);
      check("single_req_ready", 64'(req_ready), 64'b01);
      check("single_alu_srca",  64'(alu_srca),  64'd5);
      edge_wait();
      check("single_rsp_valid", 64'(rsp_valid), 64'b01);
      check("single_rsp_data",  64'(slot(0)),   64'd12);

      // opcode table through alternating requesters
      for (int v = 0; v < 12; v++) begin
         int r;
         r = v % NR;
         set_req(r, vecs[v].op, vecs[v].a, vecs[v].b);
         drive(NR'(1 << r), 2'b11, 1'b0);
         check($sformatf("vec%0d_req_ready", v), 64'(req_ready), 64'(1 << r));
         edge_wait();
         check($sformatf("vec%0d_rsp_data", v), 64'(slot(r)), 64'(vecs[v].res));
      end

      // contention: alternating grants from pointer 0
      drive(2'b00, 2'b11, 1'b1);
      edge_wait();
      set_req(0, ALU_SUB, 32'd10, 32'd3);
      set_req(1, ALU_XOR, 32'hF0, 32'h0F);
      for (int k = 0; k < 4; k++) begin
         drive(2'b11, 2'b11, 1'b0);
         check($sformatf("contend%0d_req_ready", k), 64'(req_ready), (k % 2 == 0) ? 64'b01 : 64'b10);
         edge_wait();
         check($sformatf("contend%0d_rsp_data", k), 64'(slot(k % 2)), (k % 2 == 0) ? 64'd7 : 64'hFF);
      end

      // backpressure on requester 0
      set_req(0, ALU_ADD, 32'd100, 32'd1);
      drive(2'b01, 2'b00, 1'b0);
      edge_wait();
      check("bp_fill_rsp_data0", 64'(slot(0)), 64'd101);
      for (int k = 0; k < 3; k++) begin
         set_req(0, ALU_ADD, 32'($urandom_range(0, 999)), 32'd9);
         drive(2'b11, 2'b10, 1'b0);
         check($sformatf("bp%0d_req_ready", k), 64'(req_ready), 64'b10);
         edge_wait();
         check($sformatf("bp%0d_rsp_valid0", k), 64'(rsp_valid[0]), 64'd1);
         check($sformatf("bp%0d_rsp_data0_hold", k), 64'(slot(0)), 64'd101);
      end
      set_req(0, ALU_ADD, 32'd200, 32'd2);
      drive(2'b11, 2'b11, 1'b0);
      check("bp_release_req_ready", 64'(req_ready), 64'b01);
      edge_wait();
      check("bp_refill_rsp_valid0", 64'(rsp_valid[0]), 64'd1);
      check("bp_refill_rsp_data0",  64'(slot(0)), 64'd202);

      // flush with both slots full and both requesting
      drive(2'b10, 2'b00, 1'b0);
      check("pre_flush_req_ready", 64'(req_ready), 64'b10);
      edge_wait();
      check("pre_flush_rsp_valid", 64'(rsp_valid), 64'b11);
      drive(2'b11, 2'b00, 1'b1);
      check("flush_req_ready", 64'(req_ready), 64'd0);
      edge_wait();
      check("flush_rsp_valid", 64'(rsp_valid), 64'd0);
      check("flush_rr_ptr", 64'(dut.rr_ptr_q), 64'd0);
      drive(2'b11, 2'b00, 1'b0);
      check("post_flush_grant0", 64'(req_ready), 64'b01);
      edge_wait();

      // async reset between edges
      drive(2'b00, 2'b00, 1'b0);
      check("pre_areset_rsp_valid", 64'(rsp_valid), 64'b01);
      #1;
      rst_n = 1'b0;
      #1;
      check("areset_rsp_valid", 64'(rsp_valid), 64'd0);
      check("areset_rsp_data",  64'(rsp_data),  64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // randomized traffic against the reference model
      for (int i = 0; i < NR; i++) begin
         m_valid[i] = 1'b0;
         m_data[i]  = 32'h0;
      end
      m_ptr = 0;
      for (int c = 0; c < 2000; c++) random_cycle();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
